puf_challenge_sequencer: RTL and testbench

//  Control/collection stage downstream of the 16-RO mux/counter datapath: walks RESP_BITS challenge pairs,

---
 rtl/puf_challenge_sequencer_pkg.sv | 27 ++
 rtl/puf_window_timer.sv | 27 ++
 rtl/puf_challenge_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_puf_challenge_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_challenge_sequencer_pkg.sv
// rtl/puf_challenge_sequencer_pkg.sv - shared state encoding, default widths and pair-index helper
package puf_challenge_sequencer_pkg;

    localparam int DEF_NUM_RO    = 16;
    localparam int DEF_SEL_W     = 4;
    localparam int DEF_CNT_W     = 12;
    localparam int DEF_WINDOW    = 4095;
    localparam int DEF_CLR_CYC   = 2;
    localparam int DEF_HOLD_CYC  = 3;
    localparam int DEF_RESP_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_COUNT   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_COMPARE = 3'd4,
        ST_DONE    = 3'd5
    } seq_state_t;

    // Ring-oscillator index for pair k: even member (odd=0) feeds mux1, odd member feeds mux2.
    function automatic int unsigned pair_index(input int unsigned base, input int unsigned k,
                                               input int unsigned odd, input int unsigned num_ro);
        return (base + 2 * k + odd) % num_ro;
    endfunction

endpackage

// File: rtl/puf_window_timer.sv
// rtl/puf_window_timer.sv - loadable down-counter with terminal-count flag
module puf_window_timer #(
    parameter int W = 12
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    // Loading N gives N+1 cycles before the flag is seen by the consumer's transition.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/puf_challenge_sequencer.sv
// rtl/puf_challenge_sequencer.sv - walks RO challenge pairs, times windows, collects response bits
module puf_challenge_sequencer
    import puf_challenge_sequencer_pkg::*;
#(
    parameter int NUM_RO    = DEF_NUM_RO,
    parameter int SEL_W     = DEF_SEL_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int WINDOW    = DEF_WINDOW,
    parameter int CLR_CYC   = DEF_CLR_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter int RESP_BITS = DEF_RESP_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [SEL_W-1:0]     i_challenge_base,
    input  logic [CNT_W-1:0]     i_counter1,
    input  logic [CNT_W-1:0]     i_counter2,
    output logic [SEL_W-1:0]     o_select1,
    output logic [SEL_W-1:0]     o_select2,
    output logic                 o_ro_enable,
    output logic                 o_ro_reset,
    output logic                 o_busy,
    output logic [RESP_BITS-1:0] o_response,
    output logic                 o_response_valid,
    output logic [SEL_W:0]       o_tie_count
);

    localparam int MAX_A  = (WINDOW > CLR_CYC) ? WINDOW : CLR_CYC;
    localparam int MAX_V  = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
    localparam int TMR_W  = (MAX_V < 2) ? 1 : $clog2(MAX_V + 1);
    localparam logic [TMR_W-1:0] CLR_LD  = TMR_W'(CLR_CYC - 1);
    localparam logic [TMR_W-1:0] WIN_LD  = TMR_W'(WINDOW - 1);
    localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYC - 1);
    localparam logic [SEL_W-1:0] K_LAST  = SEL_W'(RESP_BITS - 1);

    seq_state_t           r_state;
    logic [SEL_W-1:0]     r_base;
    logic [SEL_W-1:0]     r_k;
    logic [SEL_W-1:0]     r_select1;
    logic [SEL_W-1:0]     r_select2;
    logic                 r_ro_enable;
    logic                 r_ro_reset;
    logic                 r_busy;
    logic [RESP_BITS-1:0] r_response;
    logic                 r_valid;
    logic [SEL_W:0]       r_tie;

    logic                 w_tc;
    logic                 w_tmr_load;
    logic [TMR_W-1:0]     w_tmr_val;
    logic                 w_bit;
    logic                 w_tie;

    assign w_bit = (i_counter1 > i_counter2);
    assign w_tie = (i_counter1 == i_counter2);

    // Timer is reloaded on exactly the transitions the FSM takes into a timed state.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = CLR_LD;
                end
            end
            ST_CLEAR: begin
                if (w_tc) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = WIN_LD;
                end
            end
            ST_COUNT: begin
                if (w_tc) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = HOLD_LD;
                end
            end
            ST_COMPARE: begin
                if (r_k != K_LAST) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = CLR_LD;
                end
            end
            default: ;
        endcase
    end

    puf_window_timer #(
        .W (TMR_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_tc       (w_tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_k         <= '0;
            r_select1   <= '0;
            r_select2   <= '0;
            r_ro_enable <= 1'b0;
            r_ro_reset  <= 1'b1;
            r_busy      <= 1'b0;
            r_response  <= '0;
            r_valid     <= 1'b0;
            r_tie       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_base     <= i_challenge_base;
                        r_k        <= '0;
                        r_response <= '0;
                        r_tie      <= '0;
                        r_select1  <= SEL_W'(pair_index(32'(i_challenge_base), 0, 0, NUM_RO));
                        r_select2  <= SEL_W'(pair_index(32'(i_challenge_base), 0, 1, NUM_RO));
                        r_ro_reset <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (w_tc) begin
                        r_ro_reset  <= 1'b0;
                        r_ro_enable <= 1'b1;
                        r_state     <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (w_tc) begin
                        r_ro_enable <= 1'b0;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_tc) begin
                        r_state <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    r_response <= r_response | (RESP_BITS'(w_bit) << r_k);
                    if (w_tie) begin
                        r_tie <= r_tie + (SEL_W + 1)'(1);
                    end
                    if (r_k == K_LAST) begin
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_k        <= r_k + SEL_W'(1);
                        r_select1  <= SEL_W'(pair_index(32'(r_base), 32'(r_k) + 1, 0, NUM_RO));
                        r_select2  <= SEL_W'(pair_index(32'(r_base), 32'(r_k) + 1, 1, NUM_RO));
                        r_ro_reset <= 1'b1;
                        r_state    <= ST_CLEAR;
                    end
                end
                ST_DONE: begin
                    r_valid    <= 1'b0;
                    r_busy     <= 1'b0;
                    r_ro_reset <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_select1        = r_select1;
    assign o_select2        = r_select2;
    assign o_ro_enable      = r_ro_enable;
    assign o_ro_reset       = r_ro_reset;
    assign o_busy           = r_busy;
    assign o_response       = r_response;
    assign o_response_valid = r_valid;
    assign o_tie_count      = r_tie;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// tb/tb_puf_challenge_sequencer.sv - directed bench with free-running RO counter model
module tb_puf_challenge_sequencer;

    localparam int CNT_W = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [3:0]       base_in;
    logic [CNT_W-1:0] cnt1, cnt2;
    logic [3:0]       sel1, sel2;
    logic             ro_en, ro_rst, busy, valid;
    logic [7:0]       resp;
    logic [4:0]       ties;

    logic             ovr;
    logic [CNT_W-1:0] fix1, fix2;
    logic [CNT_W-1:0] m_c1, m_c2;
    int               rate [16];

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_sel_viol = 0;
    logic [3:0] prev_s1, prev_s2;
    logic       prev_en = 1'b0;

    always #5 clk = ~clk;

    puf_challenge_sequencer #(.WINDOW(16)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_challenge_base (base_in),
        .i_counter1       (cnt1),
        .i_counter2       (cnt2),
        .o_select1        (sel1),
        .o_select2        (sel2),
        .o_ro_enable      (ro_en),
        .o_ro_reset       (ro_rst),
        .o_busy           (busy),
        .o_response       (resp),
        .o_response_valid (valid),
        .o_tie_count      (ties)
    );

    // RO counters: cleared by ro_reset, advance by the selected oscillator's rate while enabled.
    always @(posedge clk) begin
        if (ro_rst) begin
            m_c1 <= '0;
            m_c2 <= '0;
        end else if (ro_en) begin
            m_c1 <= m_c1 + CNT_W'(rate[sel1]);
            m_c2 <= m_c2 + CNT_W'(rate[sel2]);
        end
    end

    assign cnt1 = ovr ? fix1 : m_c1;
    assign cnt2 = ovr ? fix2 : m_c2;

    always @(negedge clk) begin
        if (valid) n_valid <= n_valid + 1;
        if (ro_en && prev_en && (sel1 != prev_s1 || sel2 != prev_s2)) n_sel_viol <= n_sel_viol + 1;
        prev_en <= ro_en;
        prev_s1 <= sel1;
        prev_s2 <= sel2;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_rates(input int even_r, input int odd_r);
        for (int i = 0; i < 16; i++) rate[i] = (i % 2 == 0) ? even_r : odd_r;
    endtask

    task automatic pulse_start(input logic [3:0] b);
        base_in = b;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    // Called in run cycle 1 (just after the edge that accepted start); n = cycle in which valid is seen.
    task automatic wait_valid(output int n);
        n = 1;
        while (!valid && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic step(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    int n, v0;

    initial begin
        rst_n = 1'b0; start = 1'b0; base_in = 4'd0;
        ovr = 1'b0; fix1 = '0; fix2 = '0;
        set_rates(3, 2);
        step(3);
        chk("rst_sel1", sel1, 0);
        chk("rst_sel2", sel2, 0);
        chk("rst_en", ro_en, 0);
        chk("rst_rorst", ro_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_resp", resp, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ties", ties, 0);
        rst_n = 1'b1;
        step(2);

        // 1: even faster than odd -> all ones, exact latency
        v0 = n_valid;
        pulse_start(4'd0);
        chk("t1_busy_on", busy, 1);
        chk("t1_sel1", sel1, 0);
        chk("t1_sel2", sel2, 1);
        chk("t1_rorst", ro_rst, 1);
        wait_valid(n);
        chk("t1_latency", n, 177);
        chk("t1_resp", resp, 8'hFF);
        chk("t1_ties", ties, 0);
        step(1);
        chk("t1_valid_pulse", valid, 0);
        chk("t1_busy_off", busy, 0);
        chk("t1_nvalid", n_valid - v0, 1);

        // 2: odd faster -> zeros; equal rates -> zeros with 8 ties
        set_rates(2, 3);
        pulse_start(4'd0);
        wait_valid(n);
        chk("t2a_resp", resp, 8'h00);
        chk("t2a_ties", ties, 0);
        step(2);
        set_rates(5, 5);
        pulse_start(4'd0);
        wait_valid(n);
        chk("t2b_resp", resp, 8'h00);
        chk("t2b_ties", ties, 8);
        step(2);

        // mixed: pairs 0,2,5,7 have even member faster -> 8'hA5
        for (int k = 0; k < 8; k++) begin
            rate[2*k]   = 3;
            rate[2*k+1] = (k == 0 || k == 2 || k == 5 || k == 7) ? 2 : 4;
        end
        pulse_start(4'd0);
        wait_valid(n);
        chk("mix_resp", resp, 8'hA5);
        chk("mix_ties", ties, 0);
        step(2);

        // 3: base 14 wraps: (14,15) then (0,1) then (2,3)
        set_rates(3, 2);
        pulse_start(4'd14);
        base_in = 4'd5;
        chk("t3_p0_sel1", sel1, 14);
        chk("t3_p0_sel2", sel2, 15);
        step(22);
        chk("t3_p1_sel1", sel1, 0);
        chk("t3_p1_sel2", sel2, 1);
        step(2);
        chk("t3_p1_en", ro_en, 1);
        step(20);
        chk("t3_p2_sel1", sel1, 2);
        chk("t3_p2_sel2", sel2, 3);
        wait_valid(n);
        chk("t3_resp", resp, 8'hFF);
        step(2);

        // 4: start during COUNT and during DONE is ignored
        v0 = n_valid;
        pulse_start(4'd0);
        step(9);
        chk("t4_in_count", ro_en, 1);
        pulse_start(4'd7);
        chk("t4_sel_kept", sel1, 0);
        wait_valid(n);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t4_busy_off", busy, 0);
        chk("t4_rorst_idle", ro_rst, 1);
        step(5);
        chk("t4_still_idle", busy, 0);
        chk("t4_nvalid", n_valid - v0, 1);
        chk("t4_resp_hold", resp, 8'hFF);

        // 5: reset during COUNT of pair 3 aborts; a fresh run is complete
        pulse_start(4'd0);
        step(74);
        chk("t5_in_count", ro_en, 1);
        v0 = n_valid;
        rst_n = 1'b0;
        #1;
        chk("t5_rorst", ro_rst, 1);
        chk("t5_en", ro_en, 0);
        chk("t5_busy", busy, 0);
        chk("t5_resp", resp, 0);
        chk("t5_sel1", sel1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(200);
        chk("t5_no_valid", n_valid - v0, 0);
        for (int k = 0; k < 8; k++) begin
            rate[2*k]   = 3;
            rate[2*k+1] = (k == 0 || k == 2 || k == 5 || k == 7) ? 2 : 4;
        end
        pulse_start(4'd0);
        wait_valid(n);
        chk("t5_latency", n, 177);
        chk("t5_resp", resp, 8'hA5);
        step(2);

        // 6: unsigned full-width compare at the extremes
        ovr = 1'b1; fix1 = 12'hFFF; fix2 = 12'hFFE;
        pulse_start(4'd0);
        wait_valid(n);
        chk("t6a_resp", resp, 8'hFF);
        step(2);
        fix1 = 12'h000; fix2 = 12'h001;
        pulse_start(4'd0);
        wait_valid(n);
        chk("t6b_resp", resp, 8'h00);
        chk("t6b_ties", ties, 0);
        step(2);
        fix1 = 12'hFFF; fix2 = 12'hFFF;
        pulse_start(4'd0);
        wait_valid(n);
        chk("t6c_ties", ties, 8);
        step(2);

        chk("sel_stable", n_sel_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
